uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values are 2, 4, 8 and 16.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning Tick pulses per bit period.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Tick, input, 1 bit: one-Clk-wide oversample strobe from UART_BaudRate_generator.
REQ-006 The block SHALL have port WrData, input, 8 bits: byte to queue.
REQ-007 The block SHALL have port WrEn, input, 1 bit: write request, sampled each Clk.
REQ-008 The block SHALL have port Full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-009 The block SHALL have port Level, output, $clog2(DEPTH)+1 bits: number of queued bytes, excluding the byte on the line.
REQ-010 The block SHALL have port Tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port Busy, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-012 The block SHALL have port TxDone, output, 1 bit: one-Clk pulse marking the end of each stop bit.

Function
REQ-013 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each bit lasting exactly OVERSAMPLE Tick pulses.
REQ-014 A write SHALL be accepted when WrEn=1 and Full=0, storing WrData at the write pointer and incrementing Level.
REQ-015 A write SHALL be dropped when WrEn=1 and Full=1, with no change to FIFO contents or Level, even if a pop occurs in the same cycle.
REQ-016 Pointers SHALL wrap modulo DEPTH; Full SHALL be 1 exactly when Level==DEPTH.
REQ-017 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-018 IDLE: Tx=1; if Level>0, the head byte SHALL be popped into the shift register, the tick counter and bit index cleared, and the state set to START on the next edge.
REQ-019 START: Tx=0; on the Tick where the tick counter equals OVERSAMPLE-1, the counter SHALL clear and the state SHALL go to DATA.
REQ-020 DATA: Tx=shift[0]; at each bit end (tick counter = OVERSAMPLE-1 with Tick), the block SHALL shift right and increment the bit index; after bit index 7 it SHALL go to STOP.
REQ-021 STOP: Tx=1; at the bit end, TxDone SHALL pulse for that one Clk and the state SHALL return to IDLE.
REQ-022 The tick counter SHALL advance only on cycles with Tick=1; Clk cycles without Tick SHALL hold all FSM state.
REQ-023 Tx SHALL be driven from a register with no combinational path from any input.
REQ-024 Back-to-back frames: after TxDone, if Level>0 the next START SHALL begin after exactly one IDLE cycle, adding no extra stop time beyond less than one Tick period.
REQ-025 A simultaneous accepted write and IDLE pop SHALL leave Level unchanged.
REQ-026 A write into an empty FIFO while in IDLE SHALL be popped on the following edge, so Tx falls 2 Clk after the WrEn edge.
REQ-027 WrData SHALL be captured at acceptance; later changes to WrData SHALL NOT affect queued or in-flight bytes.

Reset
REQ-028 Rst_n=0 SHALL asynchronously set state=IDLE, Tx=1, Busy=0, TxDone=0, Full=0, Level=0, pointers=0, tick counter=0, bit index=0 and shift register=0.
REQ-029 Reset mid-frame SHALL abort the frame, return Tx high immediately and discard all queued bytes; after release, no transmission SHALL start until a new write.
REQ-030 Release of Rst_n SHALL be usable asynchronously to Clk; the first accepted write SHALL be possible on the first Clk edge after release.

Verification
REQ-031 With OVERSAMPLE=16, Tick every 651 Clk and a write of 8'h55 -> Tx shows 0,1,0,1,0,1,0,1,0,1 each 16 Ticks long, then TxDone pulses once and Busy falls.
REQ-032 Writing 8'hA3 and 8'h0F on consecutive cycles -> two frames with exactly one IDLE cycle between TxDone and the second start edge; the data bits of the second frame are 1,1,1,1,0,0,0,0.
REQ-033 With DEPTH=4, six writes on consecutive cycles while idle -> first byte popped, next four queued, Full=1, sixth write dropped; exactly five frames are sent.
REQ-034 While Full=1, asserting WrEn in the same cycle as an IDLE pop -> write dropped and Level goes 4->3.
REQ-035 Assert Rst_n=0 during data bit 3 of 8'hFF with 2 bytes queued -> Tx=1 with no Clk edge needed, Level=0, and no frame after release.
REQ-036 Holding Tick=0 for 10000 Clk mid-frame -> Tx, state and counters frozen; the frame resumes correctly once Tick restarts.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Each bit lasts OVERSAMPLE strobes of Tick; Clk cycles without Tick leave the sequencer frozen.
module uart_tx_fifo #(
    parameter int DEPTH      = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Tick,
    input  logic [7:0]               WrData,
    input  logic                     WrEn,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Tx,
    output logic                     Busy,
    output logic                     TxDone
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wrPtr_r;
    logic [PW-1:0] rdPtr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] levelNext_s;
    logic          full_r;
    logic [1:0]    state_r;
    logic [1:0]    stateNext_s;
    logic [CW-1:0] tickCnt_r;
    logic [CW-1:0] tickCntNext_s;
    logic [2:0]    bitIdx_r;
    logic [2:0]    bitIdxNext_s;
    logic [7:0]    shift_r;
    logic [7:0]    shiftNext_s;
    logic          tx_r;
    logic          txNext_s;
    logic          busy_r;
    logic          txDone_r;
    logic          txDoneNext_s;
    logic          accept_s;
    logic          pop_s;
    logic          bitEnd_s;

    // Next-state logic for FIFO occupancy and the frame sequencer.
    always_comb begin
        accept_s = WrEn && !full_r;
        pop_s    = (state_r == IDLE) && (level_r != {LW{1'b0}});
        bitEnd_s = Tick && (tickCnt_r == TICK_LAST);

        case ({accept_s, pop_s})
            2'b10:   levelNext_s = level_r + LW'(1);
            2'b01:   levelNext_s = level_r - LW'(1);
            default: levelNext_s = level_r;
        endcase

        stateNext_s   = state_r;
        tickCntNext_s = tickCnt_r;
        bitIdxNext_s  = bitIdx_r;
        shiftNext_s   = shift_r;
        txDoneNext_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    shiftNext_s   = mem_r[rdPtr_r];
                    tickCntNext_s = {CW{1'b0}};
                    bitIdxNext_s  = 3'd0;
                    stateNext_s   = START;
                end else begin
                    stateNext_s   = IDLE;
                end
            end
            START: begin
                if (bitEnd_s) begin
                    tickCntNext_s = {CW{1'b0}};
                    stateNext_s   = DATA;
                end else if (Tick) begin
                    tickCntNext_s = tickCnt_r + CW'(1);
                end else begin
                    tickCntNext_s = tickCnt_r;
                end
            end
            DATA: begin
                if (bitEnd_s) begin
                    tickCntNext_s = {CW{1'b0}};
                    shiftNext_s   = {1'b0, shift_r[7:1]};
                    bitIdxNext_s  = bitIdx_r + 3'd1;
                    if (bitIdx_r == 3'd7) begin
                        stateNext_s = STOP;
                    end else begin
                        stateNext_s = DATA;
                    end
                end else if (Tick) begin
                    tickCntNext_s = tickCnt_r + CW'(1);
                end else begin
                    tickCntNext_s = tickCnt_r;
                end
            end
            STOP: begin
                if (bitEnd_s) begin
                    tickCntNext_s = {CW{1'b0}};
                    txDoneNext_s  = 1'b1;
                    stateNext_s   = IDLE;
                end else if (Tick) begin
                    tickCntNext_s = tickCnt_r + CW'(1);
                end else begin
                    tickCntNext_s = tickCnt_r;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase

        // Line level follows the state being entered so Tx can come straight from a flop.
        case (stateNext_s)
            START:   txNext_s = 1'b0;
            DATA:    txNext_s = shiftNext_s[0];
            default: txNext_s = 1'b1;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            level_r <= {LW{1'b0}};
            full_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wrPtr_r] <= WrData;
                wrPtr_r        <= wrPtr_r + PW'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            level_r <= levelNext_s;
            full_r  <= (levelNext_s == LEVEL_FULL);
        end
    end

    // Frame sequencer state and registered line outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= IDLE;
            tickCnt_r <= {CW{1'b0}};
            bitIdx_r  <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            txDone_r  <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            tickCnt_r <= tickCntNext_s;
            bitIdx_r  <= bitIdxNext_s;
            shift_r   <= shiftNext_s;
            tx_r      <= txNext_s;
            busy_r    <= (stateNext_s != IDLE);
            txDone_r  <= txDoneNext_s;
        end
    end

    assign Full   = full_r;
    assign Level  = level_r;
    assign Tx     = tx_r;
    assign Busy   = busy_r;
    assign TxDone = txDone_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected bytes with their acceptance cycle,
// a line monitor decodes Tx tick by tick and checks bits, frame timing, Level, Full and Busy.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int OVS   = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          Clk;
    logic          Rst_n;
    logic          Tick;
    logic [7:0]    WrData;
    logic          WrEn;
    logic          Full;
    logic [LW-1:0] Level;
    logic          Tx;
    logic          Busy;
    logic          TxDone;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } entry_t;

    entry_t     waiting[$];
    int         nChecks    = 0;
    int         nFail      = 0;
    int         cyc        = 0;
    int         lastEnd    = -1000;
    int         framesDone = 0;
    bit         inFrame    = 1'b0;
    int         bitNum     = 0;
    int         ticks      = 0;
    logic [7:0] curByte    = 8'h00;
    logic [7:0] rxByte     = 8'h00;
    int         tickPeriod = 4;
    int         tickCtr    = 0;
    bit         tickRandom = 1'b0;
    bit         tickFreeze = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .OVERSAMPLE(OVS)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .WrData(WrData), .WrEn(WrEn),
        .Full(Full), .Level(Level), .Tx(Tx), .Busy(Busy), .TxDone(TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        nFail++;
        $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    // Tick generator: periodic, random or frozen; changes 2 time units after the edge.
    initial begin
        Tick = 1'b0;
        forever begin
            @(posedge Clk); #2;
            if (tickFreeze) begin
                Tick = 1'b0;
            end else if (tickRandom) begin
                Tick = ($urandom_range(0, 3) == 0);
            end else begin
                tickCtr++;
                if (tickCtr >= tickPeriod) begin
                    tickCtr = 0;
                    Tick = 1'b1;
                end else begin
                    Tick = 1'b0;
                end
            end
        end
    end

    // One monitor step per edge; Tick/WrEn still hold the values the DUT just sampled.
    task automatic monitorStep();
        bit     endedNow = 1'b0;
        int     expStart;
        logic   expLine;
        entry_t e;
        if (inFrame) begin
            if (Tick) ticks++;
            if (ticks == OVS) begin
                ticks = 0;
                bitNum++;
                if (bitNum == 10) begin
                    endedNow = 1'b1;
                    inFrame  = 1'b0;
                    lastEnd  = cyc;
                    framesDone++;
                    chk("frame byte", 32'(rxByte), 32'(curByte));
                    chk("txdone at stop end", 32'(TxDone), 32'd1);
                    chk("line idle after stop", 32'(Tx), 32'd1);
                end else if (bitNum == 9) begin
                    chk("stop bit", 32'(Tx), 32'd1);
                end else begin
                    chk("data bit", 32'(Tx), 32'(curByte[3'(bitNum - 1)]));
                    rxByte[3'(bitNum - 1)] = Tx;
                end
            end else begin
                expLine = (bitNum == 0) ? 1'b0 : ((bitNum == 9) ? 1'b1 : curByte[3'(bitNum - 1)]);
                if (Tx !== expLine) fail("line hold", 32'(Tx), 32'(expLine));
            end
        end else if (waiting.size() > 0) begin
            expStart = ((waiting[0].acc > lastEnd) ? waiting[0].acc : lastEnd) + 1;
            if (cyc == expStart) begin
                chk("start edge", 32'(Tx), 32'd0);
            end else if (Tx !== 1'b1) begin
                fail("start timing", 32'(cyc), 32'(expStart));
            end
            if (Tx === 1'b0) begin
                e       = waiting.pop_front();
                curByte = e.data;
                rxByte  = 8'h00;
                inFrame = 1'b1;
                ticks   = 0;
                bitNum  = 0;
            end
        end else begin
            chk("idle line", 32'(Tx), 32'd1);
        end
        if (!endedNow && TxDone !== 1'b0) fail("txdone spurious", 32'(TxDone), 32'd0);
        chk("level", 32'(Level), 32'(waiting.size()));
        chk("full", 32'(Full), 32'(waiting.size() == DEPTH));
        chk("busy", 32'(Busy), 32'(inFrame));
    endtask

    initial begin
        forever begin
            @(posedge Clk); #1;
            cyc++;
            if (!Rst_n) begin
                inFrame = 1'b0;
                lastEnd = -1000;
                ticks   = 0;
                bitNum  = 0;
            end else begin
                monitorStep();
            end
        end
    end

    // Drive the write port and record the byte if the model says it will be accepted.
    task automatic drive(input logic en, input logic [7:0] d);
        entry_t e;
        WrEn   = en;
        WrData = d;
        if (en && waiting.size() < DEPTH) begin
            e.data = d;
            e.acc  = cyc + 1;
            waiting.push_back(e);
        end
    endtask

    task automatic writeCycle(input logic en, input logic [7:0] d);
        @(posedge Clk); #2;
        drive(en, d);
    endtask

    task automatic drain();
        int n = 0;
        writeCycle(1'b0, 8'($urandom));
        while ((waiting.size() > 0 || inFrame) && n < 20000) begin
            writeCycle(1'b0, 8'($urandom));
            n++;
        end
        if (n >= 20000) fail("drain timeout", 32'(n), 32'd20000);
    endtask

    task automatic waitBit(input int b, input int t);
        int n = 0;
        while (!(inFrame && bitNum == b && ticks == t) && n < 5000) begin
            writeCycle(1'b0, 8'($urandom));
            n++;
        end
        if (n >= 5000) fail("wait bit timeout", 32'(bitNum), 32'(b));
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, " tx"}, 32'(Tx), 32'd1);
        chk({tag, " busy"}, 32'(Busy), 32'd0);
        chk({tag, " txdone"}, 32'(TxDone), 32'd0);
        chk({tag, " full"}, 32'(Full), 32'd0);
        chk({tag, " level"}, 32'(Level), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        Rst_n  = 1'b1;
        WrEn   = 1'b0;
        WrData = 8'h00;
        #2 Rst_n = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (3) @(posedge Clk);
        #3 Rst_n = 1'b1;
        // Write lands on the very first edge after an asynchronous release.
        drive(1'b1, 8'h55);
        drain();
        chk("frames after 0x55", 32'(framesDone), 32'd1);

        // Back-to-back frames with one idle cycle between them.
        tickPeriod = 3;
        writeCycle(1'b1, 8'hA3);
        writeCycle(1'b1, 8'h0F);
        drain();
        chk("frames after A3/0F", 32'(framesDone), 32'd3);

        // Six writes into a depth-4 FIFO: one popped, four queued, one dropped.
        tickPeriod = 2;
        base = framesDone;
        for (int i = 0; i < 6; i++) writeCycle(1'b1, 8'($urandom));
        writeCycle(1'b0, 8'($urandom));
        chk("full after six writes", 32'(Full), 32'd1);
        chk("level after six writes", 32'(Level), 32'd4);
        n = 0;
        while (lastEnd != cyc && n < 5000) begin
            writeCycle(1'b0, 8'($urandom));
            n++;
        end
        if (n >= 5000) fail("first frame end timeout", 32'(n), 32'd5000);
        drive(1'b1, 8'h99);
        writeCycle(1'b0, 8'($urandom));
        chk("level after full write with pop", 32'(Level), 32'd3);
        chk("full after full write with pop", 32'(Full), 32'd0);
        drain();
        chk("frames from six writes", 32'(framesDone - base), 32'd5);

        // Tick held low for 10000 Clk mid-frame, then resumed.
        tickPeriod = 3;
        writeCycle(1'b1, 8'hC6);
        waitBit(3, 5);
        tickFreeze = 1'b1;
        repeat (10000) @(posedge Clk);
        #2;
        chk("tx frozen on data bit 2", 32'(Tx), 32'd1);
        chk("busy while frozen", 32'(Busy), 32'd1);
        tickFreeze = 1'b0;
        drain();

        // Randomized writes, gaps and tick patterns.
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) begin
                tickPeriod = $urandom_range(1, 4);
                tickRandom = ($urandom_range(0, 1) == 1);
            end
            writeCycle(1'b1, 8'($urandom));
            repeat ($urandom_range(0, 300)) writeCycle(1'b0, 8'($urandom));
        end
        drain();
        tickRandom = 1'b0;

        // Reset during data bit 3 of 0xFF with two bytes queued.
        tickPeriod = 2;
        writeCycle(1'b1, 8'hFF);
        writeCycle(1'b1, 8'($urandom));
        writeCycle(1'b1, 8'($urandom));
        waitBit(4, 3);
        chk("level before reset", 32'(Level), 32'd2);
        base = framesDone;
        #1 Rst_n = 1'b0;
        waiting.delete();
        inFrame = 1'b0;
        #1 checkResetOutputs("mid-frame reset");
        repeat (2) @(posedge Clk);
        #3 Rst_n = 1'b1;
        repeat (400) writeCycle(1'b0, 8'($urandom));
        chk("no frame after reset", 32'(framesDone - base), 32'd0);
        writeCycle(1'b1, 8'h3C);
        drain();
        chk("frame after reset write", 32'(framesDone - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
